// File: rtl/find_bkt_lvl.sv
// find_bkt_lvl
// Backtrack-level search controller. A search starts from a snapshot of the
// packed per-level states {dcd_bin, has_bkt}. It walks down from the clamped
// max_lvl, one level per cycle, and stops at the first level whose decision
// has not been flipped (has_bkt == 0). Level 0 is the root. Reaching it means
// unsat. When apply_bkt_i is accepted, the controller issues a one-cycle
// write-back that sets has_bkt on the found level and zeroes every level
// above it.
//
// Ports
//   clk, rst        clock; asynchronous active-high reset
//   start_i         begin a search (honoured in IDLE only)
//   max_lvl_i       highest level to examine (sampled with start_i, clamped)
//   lvl_states_i    packed level states, level i at [i*W +: W]
//   apply_bkt_i     accept the result (honoured in DONE only)
//   busy_o          controller not idle
//   done_o          result valid, held for the whole of DONE
//   unsat_o         no unbacktracked level exists in 1..max
//   bkt_lvl_o       found level
//   bkt_bin_o       dcd_bin of the found level
//   wr_states_o     one-cycle per-level write mask
//   lvl_states_o    write-back data, valid with wr_states_o
//
// Handshake: start_i and apply_bkt_i are single-cycle requests with no
// back-pressure. start_i is accepted only when busy_o is low. apply_bkt_i is
// accepted only when done_o is high. Requests in any other state are dropped.
module find_bkt_lvl #(
    parameter int NUM_LVLS         = 8,
    parameter int WIDTH_BIN_ID     = 10,
    parameter int WIDTH_LVL_STATES = 11,
    parameter int WIDTH_LVL        = 16
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 start_i,
    input  logic [WIDTH_LVL-1:0]                 max_lvl_i,
    input  logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_i,
    input  logic                                 apply_bkt_i,
    output logic                                 busy_o,
    output logic                                 done_o,
    output logic                                 unsat_o,
    output logic [WIDTH_LVL-1:0]                 bkt_lvl_o,
    output logic [WIDTH_BIN_ID-1:0]              bkt_bin_o,
    output logic [NUM_LVLS-1:0]                  wr_states_o,
    output logic [WIDTH_LVL_STATES*NUM_LVLS-1:0] lvl_states_o
);

    localparam int CW = (NUM_LVLS > 1) ? $clog2(NUM_LVLS) : 1;
    localparam int W  = WIDTH_LVL_STATES;
    localparam int SW = WIDTH_LVL_STATES * NUM_LVLS;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SEARCH = 2'd1,
        DONE   = 2'd2,
        WRITE  = 2'd3
    } state_t;

    state_t            state;
    logic [CW-1:0]     cur;
    logic [SW-1:0]     snap;
    logic [W-1:0]      cur_word;
    logic [CW-1:0]     start_lvl;
    logic [NUM_LVLS-1:0] wb_mask;
    logic [SW-1:0]     wb_data;

    assign cur_word = snap[int'(cur)*W +: W];

    // Requests above the top level start from the top level.
    assign start_lvl = (max_lvl_i >= WIDTH_LVL'(NUM_LVLS)) ? CW'(NUM_LVLS - 1)
                                                           : max_lvl_i[CW-1:0];

    // The write-back image is built from the snapshot while DONE holds the
    // result, so the WRITE cycle only has to present registered values.
    // The found level keeps its dcd_bin and gets has_bkt set. Every level
    // above it is cleared. Levels below it are not written and carry the
    // snapshot.
    always_comb begin
        wb_mask = '0;
        wb_data = snap;
        for (int i = 0; i < NUM_LVLS; i++) begin
            if (WIDTH_LVL'(i) > bkt_lvl_o) begin
                wb_mask[i]          = 1'b1;
                wb_data[i*W +: W]   = '0;
            end else if (WIDTH_LVL'(i) == bkt_lvl_o) begin
                wb_mask[i]          = 1'b1;
                wb_data[i*W]        = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cur          <= '0;
            snap         <= '0;
            busy_o       <= 1'b0;
            done_o       <= 1'b0;
            unsat_o      <= 1'b0;
            bkt_lvl_o    <= '0;
            bkt_bin_o    <= '0;
            wr_states_o  <= '0;
            lvl_states_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start_i) begin
                        snap      <= lvl_states_i;
                        cur       <= start_lvl;
                        unsat_o   <= 1'b0;
                        bkt_lvl_o <= '0;
                        bkt_bin_o <= '0;
                        busy_o    <= 1'b1;
                        state     <= SEARCH;
                    end
                end
                SEARCH: begin
                    if (cur == '0) begin
                        unsat_o <= 1'b1;
                        done_o  <= 1'b1;
                        state   <= DONE;
                    end else if (!cur_word[0]) begin
                        bkt_lvl_o <= WIDTH_LVL'(cur);
                        bkt_bin_o <= cur_word[W-1:1];
                        done_o    <= 1'b1;
                        state     <= DONE;
                    end else begin
                        cur <= cur - 1'b1;
                    end
                end
                DONE: begin
                    if (apply_bkt_i) begin
                        done_o <= 1'b0;
                        if (unsat_o) begin
                            busy_o <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            wr_states_o  <= wb_mask;
                            lvl_states_o <= wb_data;
                            state        <= WRITE;
                        end
                    end
                end
                WRITE: begin
                    wr_states_o  <= '0;
                    lvl_states_o <= '0;
                    busy_o       <= 1'b0;
                    state        <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_find_bkt_lvl.sv
// Testbench for find_bkt_lvl. The reference model works from the level
// states directly. It finds the highest unflipped level with a plain loop,
// derives the cycle schedule from the latency formula, and builds the
// expected write-back image level by level. One compare process checks the
// outputs against the model's expectations on every clock. Directed cases
// also pin observed latency and values to hand-computed literals.
module tb_find_bkt_lvl;
    localparam int N  = 8;
    localparam int WB = 10;
    localparam int W  = 11;
    localparam int WL = 16;

    logic            clk = 1'b0;
    logic            rst;
    logic            start_i;
    logic [WL-1:0]   max_lvl_i;
    logic [W*N-1:0]  lvl_states_i;
    logic            apply_bkt_i;
    logic            busy_o, done_o, unsat_o;
    logic [WL-1:0]   bkt_lvl_o;
    logic [WB-1:0]   bkt_bin_o;
    logic [N-1:0]    wr_states_o;
    logic [W*N-1:0]  lvl_states_o;

    find_bkt_lvl #(.NUM_LVLS(N), .WIDTH_BIN_ID(WB), .WIDTH_LVL_STATES(W), .WIDTH_LVL(WL)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .max_lvl_i(max_lvl_i),
        .lvl_states_i(lvl_states_i), .apply_bkt_i(apply_bkt_i),
        .busy_o(busy_o), .done_o(done_o), .unsat_o(unsat_o),
        .bkt_lvl_o(bkt_lvl_o), .bkt_bin_o(bkt_bin_o),
        .wr_states_o(wr_states_o), .lvl_states_o(lvl_states_o)
    );

    // ---------------- clock ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc++;

    // ---------------- counters / model expectations ----------------
    int vectors = 0;
    int miscompares = 0;

    bit             chk_en = 1'b0;
    logic           exp_busy, exp_done, exp_unsat, exp_search;
    logic [WL-1:0]  exp_lvl;
    logic [WB-1:0]  exp_bin;
    logic [N-1:0]   exp_wr;
    logic [W*N-1:0] exp_data;

    // Observations captured by the compare process for the literal pins.
    int             start_cyc = 0;
    bit             done_seen = 1'b0;
    int             meas_cycle = 0;
    logic           cap_unsat;
    logic [WL-1:0]  cap_lvl;
    logic [WB-1:0]  cap_bin;
    logic [N-1:0]   cap_wr;
    logic [W*N-1:0] cap_data;
    int             wr_pulses = 0;

    task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (!rst && chk_en) begin
            check("busy", busy_o, exp_busy);
            check("done", done_o, exp_done);
            check("wr_states", wr_states_o, exp_wr);
            if (exp_done) begin
                check("unsat", unsat_o, exp_unsat);
                if (!exp_unsat) begin
                    check("bkt_lvl", bkt_lvl_o, exp_lvl);
                    check("bkt_bin", bkt_bin_o, exp_bin);
                end
            end
            if (exp_search) begin
                check("cleared_unsat", unsat_o, 1'b0);
                check("cleared_lvl", bkt_lvl_o, '0);
                check("cleared_bin", bkt_bin_o, '0);
            end
            if (exp_wr != '0) check("lvl_states", lvl_states_o, exp_data);
        end
        if (!rst) begin
            if (done_o && !done_seen) begin
                done_seen  = 1'b1;
                meas_cycle = cyc - start_cyc + 1;
                cap_unsat  = unsat_o;
                cap_lvl    = bkt_lvl_o;
                cap_bin    = bkt_bin_o;
            end
            if (wr_states_o != '0) begin
                wr_pulses++;
                cap_wr   = wr_states_o;
                cap_data = lvl_states_o;
            end
        end
    end

    // ---------------- reference model ----------------
    function automatic void model_search(input logic [W*N-1:0] st, input int m,
                                         output bit uns, output int l);
        uns = 1'b1;
        l   = 0;
        for (int i = m; i >= 1; i--) begin
            if (uns && st[i*W] == 1'b0) begin
                uns = 1'b0;
                l   = i;
            end
        end
    endfunction

    function automatic void model_write(input logic [W*N-1:0] st, input int l,
                                        output logic [N-1:0] mask, output logic [W*N-1:0] data);
        mask = '0;
        data = st;
        for (int i = 0; i < N; i++) begin
            if (i > l) begin
                mask[i] = 1'b1;
                data[i*W +: W] = '0;
            end else if (i == l) begin
                mask[i] = 1'b1;
                data[i*W +: W] = {st[i*W+1 +: WB], 1'b1};
            end
        end
    endfunction

    task automatic model_idle();
        exp_busy = 1'b0; exp_done = 1'b0; exp_search = 1'b0;
        exp_wr = '0; exp_data = '0;
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    // One full operation: start, search, DONE held for 'hold' cycles, apply.
    // Called in an IDLE cycle. Returns in the first cycle busy_o is low again.
    task automatic op(input logic [WL-1:0] max, input logic [W*N-1:0] st,
                      input int hold, input bit scramble, input bit poke);
        int m, l, lat;
        bit uns;
        logic [N-1:0] mask;
        logic [W*N-1:0] data;
        m = (max >= WL'(N)) ? N-1 : int'(max);
        model_search(st, m, uns, l);
        lat = uns ? m + 1 : m - l + 1;
        model_write(st, l, mask, data);

        start_i = 1'b1; max_lvl_i = max; lvl_states_i = st;
        tick();
        start_cyc = cyc; done_seen = 1'b0;
        start_i = poke;
        if (scramble) lvl_states_i = {$urandom, $urandom, $urandom};
        exp_busy = 1'b1; exp_done = 1'b0; exp_search = 1'b1; exp_wr = '0;
        for (int c = 1; c < lat; c++) begin
            tick();
            start_i = 1'b0;
            max_lvl_i = WL'($urandom_range(0, 20));
        end
        tick();
        start_i = 1'b0;
        exp_search = 1'b0; exp_done = 1'b1; exp_unsat = uns;
        exp_lvl = WL'(l); exp_bin = st[l*W+1 +: WB];
        for (int h = 0; h < hold; h++) begin
            if (h == 0 && poke) start_i = 1'b1;
            tick();
            start_i = 1'b0;
        end
        apply_bkt_i = 1'b1;
        tick();
        apply_bkt_i = 1'b0;
        exp_done = 1'b0;
        if (uns) begin
            exp_busy = 1'b0;
        end else begin
            exp_wr = mask; exp_data = data;
            tick();
            model_idle();
        end
    endtask

    task automatic rst_check(input string tag);
        check({tag, "_busy"}, busy_o, 1'b0);
        check({tag, "_done"}, done_o, 1'b0);
        check({tag, "_unsat"}, unsat_o, 1'b0);
        check({tag, "_lvl"}, bkt_lvl_o, '0);
        check({tag, "_bin"}, bkt_bin_o, '0);
        check({tag, "_wr"}, wr_states_o, '0);
        check({tag, "_data"}, lvl_states_o, '0);
    endtask

    function automatic logic [W*N-1:0] rand_states(input int flip_odds);
        logic [W*N-1:0] s;
        for (int i = 0; i < N; i++)
            s[i*W +: W] = {WB'($urandom_range(0, 1023)), ($urandom_range(0, flip_odds) != 0)};
        return s;
    endfunction

    // ---------------- main sequence ----------------
    initial begin
        logic [W*N-1:0] st;
        int wr_before;
        rst = 1'b1; start_i = 1'b0; apply_bkt_i = 1'b0;
        max_lvl_i = '0; lvl_states_i = '0;
        model_idle();
        exp_unsat = 1'b0; exp_lvl = '0; exp_bin = '0;
        #12;
        rst_check("reset");
        @(negedge clk); #1 rst = 1'b0;
        chk_en = 1'b1;
        tick();

        // Found: levels 7,6 flipped, level 5 open with bin 0x2A.
        st = rand_states(1000000);
        st[7*W] = 1'b1; st[6*W] = 1'b1;
        st[5*W +: W] = {10'h2A, 1'b0};
        op(16'd7, st, 2, 1'b0, 1'b0);
        check("found_cycle", meas_cycle, 4);
        check("found_lvl", cap_lvl, 5);
        check("found_bin", cap_bin, 10'h2A);
        check("found_unsat", cap_unsat, 1'b0);
        check("found_mask", cap_wr, 8'b1110_0000);
        check("found_word5", cap_data[5*W +: W], 11'h055);
        check("found_words67", cap_data[6*W +: 2*W], '0);

        // Unsat: everything flipped, max 3.
        st = rand_states(1000000);
        for (int i = 0; i < N; i++) st[i*W] = 1'b1;
        wr_before = wr_pulses;
        op(16'd3, st, 1, 1'b0, 1'b0);
        check("unsat_cycle", meas_cycle, 5);
        check("unsat_flag", cap_unsat, 1'b1);
        tick();
        check("unsat_no_write", wr_pulses, wr_before);

        // Clamp: max 20 with level 7 open; then max 0.
        st = rand_states(1000000);
        st[7*W] = 1'b0;
        op(16'd20, st, 0, 1'b0, 1'b0);
        check("clamp_cycle", meas_cycle, 2);
        check("clamp_lvl", cap_lvl, 7);
        st = rand_states(1);
        op(16'd0, st, 0, 1'b0, 1'b0);
        check("max0_cycle", meas_cycle, 2);
        check("max0_unsat", cap_unsat, 1'b1);

        // Snapshot, dropped starts and a 10-cycle DONE hold.
        st = rand_states(1000000);
        st[2*W] = 1'b0;
        op(16'd6, st, 10, 1'b1, 1'b1);
        check("snap_lvl", cap_lvl, 2);

        // Back-to-back: next start in the cycle busy_o falls.
        st = rand_states(1000000);
        st[4*W] = 1'b0;
        op(16'd7, st, 0, 1'b0, 1'b0);
        st = rand_states(1000000);
        st[6*W] = 1'b0;
        op(16'd7, st, 0, 1'b0, 1'b0);
        check("b2b_cycle", meas_cycle, 3);
        check("b2b_lvl", cap_lvl, 6);

        // Randomized operations.
        for (int k = 0; k < 40; k++) begin
            op(WL'($urandom_range(0, 20)), rand_states(3), $urandom_range(0, 3),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 2) == 0) tick();
        end

        // Asynchronous reset in the middle of a search.
        st = rand_states(1000000);
        for (int i = 0; i < N; i++) st[i*W] = 1'b1;
        start_i = 1'b1; max_lvl_i = 16'd7; lvl_states_i = st;
        tick();
        start_i = 1'b0;
        exp_busy = 1'b1; exp_search = 1'b1;
        tick();
        #1 rst = 1'b1;
        #1 rst_check("midrst");
        model_idle();
        wr_before = wr_pulses;
        @(negedge clk); #1 rst = 1'b0;
        repeat (10) tick();
        check("midrst_no_write", wr_pulses, wr_before);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/find_bkt_lvl.md
# find_bkt_lvl

Backtrack-level search controller for the Sat Engine. It consumes the packed per-level states (`{dcd_bin, has_bkt}`) maintained by the level-state array and, on conflict, scans downward from `max_lvl` for the highest level whose decision has not yet been flipped. It reports that level and its decision bin, then, on the engine's `apply_bkt` command, produces the write-back that marks the level backtracked and clears all levels above it.

## Interface
- NUM_LVLS, 8, number of decision levels held (level 0 = root, never backtracked)
- WIDTH_BIN_ID, 10, width of a decision bin id
- WIDTH_LVL_STATES, 11, per-level state width; always WIDTH_BIN_ID+1
- WIDTH_LVL, 16, width of level numbers
- clk  in  1  clock
- rst  in  1  reset; one clock, asynchronous, active-high
- start_i  in  1  one-cycle request to begin a search; honoured only in IDLE
- max_lvl_i  in  WIDTH_LVL  highest level to examine; sampled with start_i
- lvl_states_i  in  WIDTH_LVL_STATES*NUM_LVLS  level i at bits [i*W +: W]; within a word, [W-1:1] is dcd_bin and [0] is has_bkt
- apply_bkt_i  in  1  engine accepts the result; honoured only in DONE
- busy_o  out  1  state != IDLE
- done_o  out  1  result valid; held high throughout DONE
- unsat_o  out  1  qualified by done_o; no unbacktracked level exists in 1..max
- bkt_lvl_o  out  WIDTH_LVL  found level; qualified by done_o && !unsat_o
- bkt_bin_o  out  WIDTH_BIN_ID  dcd_bin of the found level
- wr_states_o  out  NUM_LVLS  one-cycle write mask, asserted in WRITE only
- lvl_states_o  out  WIDTH_LVL_STATES*NUM_LVLS  write-back data, valid with wr_states_o

## Operation
- States: IDLE, SEARCH, DONE, WRITE.
- **IDLE:**
  - If start_i is high: snapshot lvl_states_i into an internal register.
  - Load cur = min(max_lvl_i, NUM_LVLS-1). Values at or above NUM_LVLS are clamped.
  - Clear unsat, bkt_lvl and bkt_bin, then go to SEARCH.
- **SEARCH:** examine one level per cycle, using snapshot level `cur`.
  - If cur == 0: set unsat and go to DONE.
  - Else if has_bkt[cur] == 0: latch bkt_lvl = cur and bkt_bin = dcd_bin[cur], then go to DONE.
  - Else: cur <= cur-1 and stay in SEARCH.
- **DONE:**
  - done_o is high. Outputs are stable until exit.
  - apply_bkt_i with unsat set: go to IDLE; no write is issued.
  - apply_bkt_i with unsat clear: go to WRITE.
  - start_i is ignored in this state.
- **WRITE:** lasts one cycle, then returns to IDLE.
  - wr_states_o[i] = 1 for every i >= bkt_lvl; all other bits are 0.
  - Level bkt_lvl is written as {dcd_bin unchanged, has_bkt = 1}.
  - Levels above bkt_lvl are written as all-zero.
  - Fields in lvl_states_o whose wr_states_o bit is 0 are don't-care; drive them with the snapshot.
- lvl_states_i changes after start_i has no effect on the operation in progress (the snapshot is used).
- start_i while busy_o is high is dropped. It is not queued.

## Timing
- Reset (asynchronous): state = IDLE, and every output is 0 (busy_o, done_o, unsat_o, bkt_lvl_o, bkt_bin_o, wr_states_o, lvl_states_o). The snapshot is cleared.
- Reset mid-operation aborts immediately. No write is issued, and the first post-reset cycle is IDLE.
- Let start_i be sampled at edge 0 and M = clamped max. The search ends at level L:
  - found: done_o rises in cycle 2+(M-L), i.e. after M-L+1 SEARCH cycles.
  - unsat: done_o rises in cycle 2+M.
- max_lvl_i = 0 gives unsat, with done_o high in cycle 2.
- apply_bkt_i sampled at edge k in DONE:
  - wr_states_o is high for exactly cycle k+1.
  - busy_o falls in cycle k+2, and a new start_i is accepted at that edge.
- done_o falls in the cycle after apply_bkt_i is sampled.
- All outputs are registered. There is no combinational path from input to output.

## Test plan
- **Reset:** assert rst asynchronously mid-SEARCH (max = 7, all has_bkt = 1) -> all outputs read 0 at once, and no wr_states_o pulse follows.
- **Found:** has_bkt = 1 at levels 7 and 6, 0 at level 5, dcd_bin[5] = 0x2A; start with max = 7 -> done_o in cycle 4, bkt_lvl = 5, bkt_bin = 0x2A, unsat = 0. Then apply -> wr_states_o = 8'b1110_0000, level 5 word = {0x2A, 1}, levels 6-7 = 0.
- **Unsat:** all has_bkt = 1, max = 3 -> done_o in cycle 5 with unsat = 1. Apply -> return to IDLE with no wr_states_o pulse.
- **Clamp:** max = 20, has_bkt[7] = 0 -> bkt_lvl = 7 with done_o in cycle 2. Separately, max = 0 -> unsat with done_o in cycle 2.
- **Snapshot and hold:**
  - Change lvl_states_i during SEARCH -> the result reflects the snapshot.
  - Pulse start_i in SEARCH and in DONE -> ignored.
  - Hold DONE for 10 cycles -> outputs stay stable.
- **Back-to-back:** assert start_i in the cycle busy_o falls after a WRITE -> a new search begins, done_o timing matches the formula, and the previous result is cleared.
